// File: rtl/m_wb_uart_pkg.sv
// Shared register offsets, STATUS bit positions and FSM encodings for m_wb_uart.
package m_wb_uart_pkg;

  localparam logic [1:0] UART_DATA = 2'd0;
  localparam logic [1:0] UART_STAT = 2'd1;
  localparam logic [1:0] UART_DIV  = 2'd2;

  localparam int ST_TXBUSY  = 0;
  localparam int ST_RXVALID = 1;
  localparam int ST_RXOVR   = 2;
  localparam int ST_RXFERR  = 3;
  localparam int ST_TXDROP  = 4;

  // IDLE | line idle ; START | start bit ; DATA | 8 data bits ; STOP | stop bit
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/m_uart_rx.sv
// 8N1 receiver: 2-FF synchroniser, mid-bit sampling FSM, shift register, frame-error flag.
module m_uart_rx
  import m_wb_uart_pkg::*;
#(
  parameter int DIVWIDTH = 16
) (
  input  logic                CLK_I,
  input  logic                RST_I_n,
  input  logic [DIVWIDTH-1:0] div_i,
  input  logic                rx_i,
  output logic [7:0]          byte_o,
  output logic                done_o,
  output logic                ferr_o
);

  logic                r_sync1, r_sync2;
  rx_state_t           r_state;
  logic [DIVWIDTH-1:0] r_cnt;
  logic [2:0]          r_bit;
  logic [7:0]          r_shift;
  logic                r_done, r_ferr;

  always_ff @(posedge CLK_I or negedge RST_I_n) begin
    if (!RST_I_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_done  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (!r_sync2) begin
            r_state <= RX_START;
            r_cnt   <= div_i >> 1;
          end
        end
        RX_START: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_sync2) begin
            r_state <= RX_DATA;
            r_cnt   <= div_i;
            r_bit   <= '0;
          end else begin
            r_state <= RX_IDLE;   // glitch shorter than half a bit
          end
        end
        RX_DATA: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_shift <= {r_sync2, r_shift[7:1]};
            r_cnt   <= div_i;
            if (r_bit == 3'd7) r_state <= RX_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end
        end
        RX_STOP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_done  <= 1'b1;
            r_ferr  <= !r_sync2;
            r_state <= RX_IDLE;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign byte_o = r_shift;
  assign done_o = r_done;
  assign ferr_o = r_ferr;

endmodule

// File: rtl/m_wb_uart.sv
// Wishbone-classic 8N1 UART slave: bus decode, status flags, divisor and TX FSM.
module m_wb_uart
  import m_wb_uart_pkg::*;
#(
  parameter int DEFAULT_DIV = 207,
  parameter int DIVWIDTH    = 16
) (
  input  logic        CLK_I,
  input  logic        RST_I_n,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [1:0]  ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        irq_o
);

  logic                r_ack;
  logic [31:0]         r_dat;
  logic [DIVWIDTH-1:0] r_div;
  tx_state_t           r_tx_state;
  logic [DIVWIDTH-1:0] r_tx_cnt;
  logic [2:0]          r_tx_bit;
  logic [7:0]          r_tx_shift;
  logic                r_tx;
  logic [7:0]          r_rxbyte;
  logic                r_rxvalid, r_rxovr, r_rxferr, r_txdrop;

  logic        w_acc, w_wr, w_rd_data, w_txbusy, w_tx_load;
  logic [31:0] w_rdata;
  logic [7:0]  w_rx_byte;
  logic        w_rx_done, w_rx_ferr;
  logic        w_unused;

  assign w_acc     = CYC_I && STB_I && !r_ack;
  assign w_wr      = w_acc && WE_I;
  assign w_rd_data = w_acc && !WE_I && (ADR_I == UART_DATA);
  assign w_txbusy  = (r_tx_state != TX_IDLE);
  assign w_tx_load = w_wr && (ADR_I == UART_DATA) && !w_txbusy;
  assign w_unused  = &{1'b0, DAT_I[31:DIVWIDTH]};

  always_comb begin
    w_rdata = '0;
    case (ADR_I)
      UART_DATA: w_rdata[7:0] = r_rxbyte;
      UART_STAT: begin
        w_rdata[ST_TXBUSY]  = w_txbusy;
        w_rdata[ST_RXVALID] = r_rxvalid;
        w_rdata[ST_RXOVR]   = r_rxovr;
        w_rdata[ST_RXFERR]  = r_rxferr;
        w_rdata[ST_TXDROP]  = r_txdrop;
      end
      UART_DIV:  w_rdata = 32'(r_div);
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I_n) begin
    if (!RST_I_n) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_div     <= DIVWIDTH'(DEFAULT_DIV);
      r_rxbyte  <= '0;
      r_rxvalid <= 1'b0;
      r_rxovr   <= 1'b0;
      r_rxferr  <= 1'b0;
      r_txdrop  <= 1'b0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc && !WE_I) ? w_rdata : '0;
      if (w_wr && (ADR_I == UART_DIV)) r_div <= DAT_I[DIVWIDTH-1:0];
      if (w_wr && (ADR_I == UART_STAT)) begin
        if (DAT_I[ST_RXOVR])  r_rxovr  <= 1'b0;
        if (DAT_I[ST_RXFERR]) r_rxferr <= 1'b0;
        if (DAT_I[ST_TXDROP]) r_txdrop <= 1'b0;
      end
      if (w_wr && (ADR_I == UART_DATA) && w_txbusy) r_txdrop <= 1'b1;
      // a read landing on the delivery edge frees the slot for the new byte
      if (w_rx_done) begin
        if (w_rx_ferr) r_rxferr <= 1'b1;
        if (!r_rxvalid || w_rd_data) begin
          r_rxbyte  <= w_rx_byte;
          r_rxvalid <= 1'b1;
        end else begin
          r_rxovr <= 1'b1;
        end
      end else if (w_rd_data) begin
        r_rxvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I_n) begin
    if (!RST_I_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_load) begin
            r_tx_state <= TX_START;
            r_tx_cnt   <= r_div;
            r_tx_shift <= DAT_I[7:0];
            r_tx_bit   <= '0;
            r_tx       <= 1'b0;
          end
        end
        TX_START: begin
          if (r_tx_cnt != '0) begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end else begin
            r_tx_state <= TX_DATA;
            r_tx_cnt   <= r_div;
            r_tx       <= r_tx_shift[0];
          end
        end
        TX_DATA: begin
          if (r_tx_cnt != '0) begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end else begin
            r_tx_cnt <= r_div;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= TX_STOP;
              r_tx       <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= r_tx_shift >> 1;
              r_tx       <= r_tx_shift[1];
            end
          end
        end
        TX_STOP: begin
          if (r_tx_cnt != '0) r_tx_cnt   <= r_tx_cnt - 1'b1;
          else                r_tx_state <= TX_IDLE;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  m_uart_rx #(.DIVWIDTH(DIVWIDTH)) u_rx (
    .CLK_I  (CLK_I),
    .RST_I_n(RST_I_n),
    .div_i  (r_div),
    .rx_i   (rx_i),
    .byte_o (w_rx_byte),
    .done_o (w_rx_done),
    .ferr_o (w_rx_ferr)
  );

  assign DAT_O = r_dat;
  assign ACK_O = r_ack;
  assign tx_o  = r_tx;
  assign irq_o = r_rxvalid;

endmodule
